count_seq_ctrl: RTL and testbench

Gated event-counting sequencer. It owns an 8-bit enable/clear counter and runs one measurement per `start`: clear the counter, count `event_in` pulses over a programmable window of clock cycles, then present the count on a valid/ready result port. It sits between the control/register side, which issues `start` and `gate_len`, and the consumer of measurement results.

---
 rtl/count_seq_pkg.sv | 17 +
 rtl/count_seq_ctrl_core.sv | 62 ++++++
 rtl/count_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_count_seq_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared types and defaults for the gated event-counting sequencer.
//   state_e          - measurement FSM states (IDLE, CLEAR, GATE, HOLD)
//   COUNT_WIDTH_DEF  - default counter/result width
//   GATE_W_DEF       - default gate-length field width
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GATE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int COUNT_WIDTH_DEF = 8;
  localparam int GATE_W_DEF      = 8;

endpackage

// File: rtl/count_seq_ctrl_core.sv
// count_core: enable/clear event counter.
// Build option: COUNT_SAT_EN - when defined the counter saturates at all-ones,
// otherwise it wraps modulo 2^WIDTH.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high
//   clr    in   clear counter to zero (has priority over en)
//   en     in   increment enable
//   count  out  WIDTH-bit counter value (registered)
//   wrap   out  an increment is being attempted at the maximum value this cycle
module count_core
  import count_seq_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // The overflow owner needs to know about the attempt, independent of mode.
  assign wrap  = en & ~clr & (count_q == CNT_MAX);
  assign count = count_q;

  // Next counter value: clear, hold, increment, or wrap/saturate at max.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (en) begin
      if (count_q == CNT_MAX) begin
`ifdef COUNT_SAT_EN
        count_d = CNT_MAX;
`else
        count_d = {WIDTH{1'b0}};
`endif
      end else begin
        count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: gated event-counting sequencer. Each accepted start clears
// the counter, counts event_in over gate_len cycles, then offers the count on a
// valid/ready result port.
// Build option: COUNT_SAT_EN (passed through to count_core) selects saturating
// instead of wrapping counter arithmetic; overflow behaves the same either way.
// Ports:
//   clk, reset        clock / synchronous active-high reset
//   start             request measurement (sampled only in IDLE)
//   abort             cancel measurement in CLEAR or GATE
//   gate_len          window length in cycles, latched on start
//   event_in          counted once per cycle while in GATE
//   busy              high outside IDLE
//   result            measured count, valid with result_valid
//   result_valid      result handshake valid
//   result_ready      result handshake ready
//   overflow          counter was incremented at its max during this measurement
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = COUNT_WIDTH_DEF,
  parameter int GATE_W = GATE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              event_in,
  output logic              busy,
  output logic [WIDTH-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overflow
);

  state_e            state_d, state_q;
  logic [GATE_W-1:0] timer_d, timer_q;
  logic              overflow_d, overflow_q;
  logic              busy_d, busy_q;
  logic              valid_d, valid_q;

  logic              cnt_clr_s;
  logic              cnt_en_s;
  logic              cnt_wrap_s;
  logic [WIDTH-1:0]  cnt_count_s;

  // Counter is also cleared on start acceptance so a zero-length window goes
  // straight to HOLD with a zero result.
  assign cnt_clr_s = ((state_q == ST_IDLE) & start) | (state_q == ST_CLEAR);
  assign cnt_en_s  = (state_q == ST_GATE) & event_in;

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .count (cnt_count_s),
    .wrap  (cnt_wrap_s)
  );

  // FSM next-state, window timer and sticky overflow.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          timer_d    = gate_len;
          overflow_d = 1'b0;
          if (gate_len == {GATE_W{1'b0}}) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_CLEAR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        overflow_d = 1'b0;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GATE;
        end
      end
      ST_GATE: begin
        overflow_d = overflow_q | cnt_wrap_s;
        // abort takes priority even on the final window cycle
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - GATE_W'(1);
          if (timer_q == GATE_W'(1)) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_GATE;
          end
        end
      end
      ST_HOLD: begin
        // result_valid is high throughout HOLD, so ready alone completes it
        if (result_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_HOLD);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= {GATE_W{1'b0}};
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = cnt_count_s;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed bench for count_seq_ctrl. Two instances (WIDTH 8
// and WIDTH 4) share all stimulus; a measurement-level model predicts busy,
// result_valid, result and overflow for both every cycle.
// Honours COUNT_SAT_EN for the narrow instance's expected result.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, event_in, result_ready;
  logic [7:0] gate_len;
  logic       busy8, valid8, ovf8, busy4, valid4, ovf4;
  logic [7:0] res8;
  logic [3:0] res4;

  int checks = 0;
  int errors = 0;

`ifdef COUNT_SAT_EN
  localparam int R4_200 = 15;
  localparam int R4_20  = 15;
`else
  localparam int R4_200 = 8;
  localparam int R4_20  = 4;
`endif

  always #5 clk = ~clk;

  count_seq_ctrl #(.WIDTH(8), .GATE_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .gate_len(gate_len),
    .event_in(event_in), .busy(busy8), .result(res8), .result_valid(valid8),
    .result_ready(result_ready), .overflow(ovf8)
  );

  count_seq_ctrl #(.WIDTH(4), .GATE_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .gate_len(gate_len),
    .event_in(event_in), .busy(busy4), .result(res4), .result_valid(valid4),
    .result_ready(result_ready), .overflow(ovf4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Measurement model: m_k = cycles since start acceptance (1 = clear cycle,
  // 2..n+1 = window, n+2 onward = result offered); zero-length offers at once.
  bit m_init = 1'b0;
  bit m_act  = 1'b0;
  int m_k, m_n, m_ev;

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1'b1;
      m_act  = 1'b0;
      m_ev   = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1; m_k = 1; m_n = int'(gate_len); m_ev = 0;
      end
    end else if (m_n > 0 && m_k <= m_n + 1) begin
      if (abort) m_act = 1'b0;
      else begin
        if (m_k >= 2 && event_in) m_ev++;
        m_k++;
      end
    end else begin
      if (result_ready) m_act = 1'b0;
    end
  end

  function automatic bit m_valid();
    return m_act && (m_n == 0 || m_k >= m_n + 2);
  endfunction

  function automatic int m_res4();
`ifdef COUNT_SAT_EN
    return (m_ev > 15) ? 15 : m_ev;
`else
    return m_ev % 16;
`endif
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("busy8", busy8, m_act);
      chk("valid8", valid8, m_valid());
      chk("busy4", busy4, m_act);
      chk("valid4", valid4, m_valid());
      if (m_valid()) begin
        chk("result8", res8, m_ev % 256);
        chk("overflow8", ovf8, m_ev > 255);
        chk("result4", res4, m_res4());
        chk("overflow4", ovf4, m_ev > 15);
      end
    end
  end

  // mode: 1 = event every cycle, 2 = alternating starting high in first window cycle
  task automatic meas(input logic [7:0] len, input int mode, input int stall, input bit pulse,
                      input int e8, input int e4, input int eo4);
    int c;
    logic [7:0] r8;
    gate_len = len; start = 1'b1; event_in = 1'b0; result_ready = (stall == 0);
    @(posedge clk); @(negedge clk);
    gate_len = 8'hA5;
    c = 1;
    while (valid8 !== 1'b1 && c < 600) begin
      start    = pulse && (c == 3);
      event_in = (mode == 1) ? 1'b1 : ((c >= 2) && (c % 2 == 0));
      @(posedge clk); @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("latency", c, (len == 8'd0) ? 1 : int'(len) + 2);
    chk("lit_result8", res8, e8);
    chk("lit_result4", res4, e4);
    chk("lit_overflow4", ovf4, eo4);
    r8 = res8;
    event_in = 1'b1;
    for (int i = 0; i < stall; i++) begin
      start = pulse; result_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("stall_valid", valid8, 1);
      chk("stall_stable", res8, r8);
    end
    result_ready = 1'b1; start = pulse;
    @(posedge clk); @(negedge clk);
    start = 1'b0; event_in = 1'b0;
    chk("idle_after_hs", busy8, 0);
    if (pulse) begin
      repeat (3) begin @(posedge clk); @(negedge clk); end
      chk("no_second_result", busy8 | valid8, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; event_in = 1'b0;
    result_ready = 1'b0; gate_len = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_result", res8, 0);
    chk("rst_overflow", ovf8, 0);
    reset = 1'b0;
    @(negedge clk);

    meas(8'd5,   1, 0, 1'b0, 5,   5,      0);
    meas(8'd10,  2, 4, 1'b0, 5,   5,      0);
    meas(8'd0,   1, 0, 1'b0, 0,   0,      0);
    meas(8'd200, 1, 0, 1'b0, 200, R4_200, 1);
    meas(8'd20,  1, 0, 1'b0, 20,  R4_20,  1);
    meas(8'd255, 1, 0, 1'b0, 255, 15,     1);

    // abort in the third window cycle
    gate_len = 8'd10; start = 1'b1; event_in = 1'b1; result_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 4; c++) begin @(posedge clk); @(negedge clk); end
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_valid", valid8, 0);
    repeat (12) begin @(posedge clk); @(negedge clk); end
    chk("abort_no_result", valid8 | busy8, 0);

    // start pulsed during window, hold, and handshake: one result only
    meas(8'd6, 1, 2, 1'b1, 6, 6, 0);

    // reset mid-window
    gate_len = 8'd10; start = 1'b1; event_in = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 5; c++) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy8, 0);
    chk("midrst_valid", valid8, 0);
    chk("midrst_result", res8, 0);
    chk("midrst_result4", res4, 0);
    chk("midrst_overflow", ovf8, 0);
    event_in = 1'b0;
    meas(8'd3, 1, 0, 1'b0, 3, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
